// File: rtl/interconn_pkg.sv
// Shared constants and arbitration helpers for the interconn crossbar.
// Optional build macro: INTERCONN_RR_ARB_EN (round-robin arbitration per destination).
package interconn_pkg;

  localparam int N_DEF     = 8;
  localparam int W_DEF     = 64;
  localparam int BADDR_DEF = 15;

  // Helpers operate on a fixed wide vector; callers zero-extend narrower requests.
  localparam int N_MAX = 32;

  // Isolate the lowest set bit (two's-complement trick); zero in gives zero out.
  function automatic logic [N_MAX-1:0] onehot_lowest(input logic [N_MAX-1:0] req);
    return req & (~req + N_MAX'(1));
  endfunction

  // Round-robin pick: search starts one above the one-hot pointer, wrapping at n.
  function automatic logic [N_MAX-1:0] rr_pick(input logic [N_MAX-1:0] req,
                                               input logic [N_MAX-1:0] ptr,
                                               input int               n);
    logic [N_MAX-1:0] gnt;
    int               start;
    logic             found;
    gnt   = '0;
    start = 0;
    found = 1'b0;
    for (int k = 0; k < N_MAX; k++) begin
      if (k < n && ptr[k]) start = (k + 1 == n) ? 0 : k + 1;
    end
    for (int o = 0; o < N_MAX; o++) begin
      int idx;
      idx = start + o;
      if (idx >= n) idx = idx - n;
      if (o < n && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/interconn_arb.sv
// Per-destination arbiter: combinational one-hot grant from an N-bit request vector.
// Fixed lowest-index priority by default; INTERCONN_RR_ARB_EN adds a one-hot
// last-grant pointer giving round-robin fairness.
module interconn_arb
  import interconn_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  logic [N_MAX-1:0] req_ext;
  logic [N_MAX-1:0] gnt_ext;
  logic             unused_hi;

  assign req_ext   = N_MAX'(req);
  assign gnt       = gnt_ext[N-1:0];
  assign unused_hi = ^gnt_ext;

`ifdef INTERCONN_RR_ARB_EN
  logic [N-1:0]     ptr_q;
  logic [N_MAX-1:0] ptr_ext;

  assign ptr_ext = N_MAX'(ptr_q);
  assign gnt_ext = rr_pick(req_ext, ptr_ext, N);

  // Last-grant pointer: resets to source N-1 so source 0 leads; holds on idle cycles.
  always_ff @(posedge clk) begin
    if (clr)       ptr_q <= N'(1) << (N - 1);
    else if (|req) ptr_q <= gnt;
  end
`else
  logic unused_ctrl;

  assign unused_ctrl = clk ^ clr;
  assign gnt_ext     = onehot_lowest(req_ext);
`endif

endmodule

// File: rtl/interconn.sv
// N-port registered crossbar: each source pushes (addr, word) to one or more
// destinations; every destination arbitrates independently and registers the
// winner with one cycle of latency. Losers are dropped (no backpressure).
// Optional build macro: INTERCONN_RR_ARB_EN selects round-robin arbitration.
module interconn
  import interconn_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int BADDR = BADDR_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [N*N-1:0]     send_to,
  input  logic [N-1:0]       send_en,
  input  logic [N*BADDR-1:0] send_addr,
  input  logic [N*W-1:0]     send_word,
  output logic [N*N-1:0]     recv_from,
  output logic [N-1:0]       recv_en,
  output logic [N*BADDR-1:0] recv_addr,
  output logic [N*W-1:0]     recv_word
);

  logic [N-1:0][N-1:0] req_p0;
  logic [N-1:0][N-1:0] gnt_p0;
  logic [N-1:0]        vld_p0;
  logic [N*BADDR-1:0]  addr_p0;
  logic [N*W-1:0]      word_p0;

  // Request matrix, indexed [destination][source]; send_to is ignored without send_en.
  always_comb begin
    req_p0 = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        req_p0[j][i] = send_en[i] & send_to[i*N+j];
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_arb
    interconn_arb #(.N(N)) u_arb (
      .clk (clk),
      .clr (clr),
      .req (req_p0[j]),
      .gnt (gnt_p0[j])
    );
  end

  // One-hot mux of winner addr/word per destination; idle destinations yield zero.
  always_comb begin
    vld_p0  = '0;
    addr_p0 = '0;
    word_p0 = '0;
    for (int j = 0; j < N; j++) begin
      vld_p0[j] = |gnt_p0[j];
      for (int i = 0; i < N; i++) begin
        if (gnt_p0[j][i]) begin
          addr_p0[j*BADDR +: BADDR] = send_addr[i*BADDR +: BADDR];
          word_p0[j*W +: W]         = send_word[i*W +: W];
        end
      end
    end
  end

  // ---- stage p0 -> outputs: register every delivery field; clr wipes all of them ----
  always_ff @(posedge clk) begin
    if (clr) begin
      recv_en   <= '0;
      recv_from <= '0;
      recv_addr <= '0;
      recv_word <= '0;
    end else begin
      recv_en   <= vld_p0;
      recv_from <= gnt_p0;
      recv_addr <= addr_p0;
      recv_word <= word_p0;
    end
  end

endmodule

// File: tb/tb_interconn.sv
// Directed self-checking bench for the interconn crossbar.
module tb_interconn;

  localparam int N     = 8;
  localparam int W     = 64;
  localparam int BADDR = 15;

  logic               clk = 1'b0;
  logic               clr;
  logic [N*N-1:0]     send_to;
  logic [N-1:0]       send_en;
  logic [N*BADDR-1:0] send_addr;
  logic [N*W-1:0]     send_word;
  logic [N*N-1:0]     recv_from;
  logic [N-1:0]       recv_en;
  logic [N*BADDR-1:0] recv_addr;
  logic [N*W-1:0]     recv_word;

  int total = 0;
  int bad   = 0;

  logic [N-1:0]       exp_en;
  logic [N-1:0]       exp_src;
  logic [W-1:0]       exp_word;
  logic [N*N-1:0]     exp_from;

  interconn #(.N(N), .W(W), .BADDR(BADDR)) dut (
    .clk       (clk),
    .clr       (clr),
    .send_to   (send_to),
    .send_en   (send_en),
    .send_addr (send_addr),
    .send_word (send_word),
    .recv_from (recv_from),
    .recv_en   (recv_en),
    .recv_addr (recv_addr),
    .recv_word (recv_word)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    send_en   = '0;
    send_to   = '0;
    send_addr = '0;
    send_word = '0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    for (int c = 0; c < 10; c++) begin
      send_en   = N'($urandom);
      send_to   = {$urandom, $urandom};
      send_addr = (N*BADDR)'({$urandom, $urandom, $urandom, $urandom});
      for (int k = 0; k < N; k++) send_word[k*W +: W] = {$urandom, $urandom};
      tick();
      total++;
      if (recv_en !== '0 || recv_from !== '0 || recv_addr !== '0 || recv_word !== '0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d en=%h from=%h addr=%h want all zero", c, recv_en, recv_from, recv_addr);
      end
    end
    clr = 1'b0;
    idle_inputs();
    tick();
    total++;
    if (recv_en !== '0 || recv_from !== '0 || recv_addr !== '0 || recv_word !== '0) begin
      bad++;
      $display("FAIL reset_release en=%h from=%h want all zero", recv_en, recv_from);
    end
  endtask

  task automatic test_one_to_one();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i != j) begin
          idle_inputs();
          send_en                     = N'(1) << i;
          send_to                     = (N*N)'(1) << (i*N + j);
          send_addr[i*BADDR +: BADDR] = 15'd7;
          send_word[i*W +: W]         = 64'hdeadbeefdeadbeef;
          tick();
          exp_en   = N'(1) << j;
          exp_from = (N*N)'(1) << (j*N + i);
          total++;
          if (recv_en !== exp_en) begin
            bad++;
            $display("FAIL p2p_en i=%0d j=%0d got=%h want=%h", i, j, recv_en, exp_en);
          end
          total++;
          if (recv_from !== exp_from) begin
            bad++;
            $display("FAIL p2p_from i=%0d j=%0d got=%h want=%h", i, j, recv_from, exp_from);
          end
          total++;
          if (recv_addr[j*BADDR +: BADDR] !== 15'd7 || recv_word[j*W +: W] !== 64'hdeadbeefdeadbeef) begin
            bad++;
            $display("FAIL p2p_data i=%0d j=%0d addr=%h word=%h want 0007/deadbeefdeadbeef",
                     i, j, recv_addr[j*BADDR +: BADDR], recv_word[j*W +: W]);
          end
        end
      end
    end
  endtask

  task automatic test_multicast();
    idle_inputs();
    send_en                     = 8'h04;
    send_to[2*N + 0]            = 1'b1;
    send_to[2*N + 5]            = 1'b1;
    send_to[2*N + 7]            = 1'b1;
    send_to[5*N +: N]           = 8'hff;
    send_addr[2*BADDR +: BADDR] = 15'h1234;
    send_word[2*W +: W]         = 64'ha5a5a5a5a5a5a5a5;
    tick();
    total++;
    if (recv_en !== 8'ha1) begin
      bad++;
      $display("FAIL mcast_en got=%h want=a1", recv_en);
    end
    for (int j = 0; j < N; j++) begin
      if (j == 0 || j == 5 || j == 7) begin
        total++;
        if (recv_from[j*N +: N] !== 8'h04 || recv_addr[j*BADDR +: BADDR] !== 15'h1234 ||
            recv_word[j*W +: W] !== 64'ha5a5a5a5a5a5a5a5) begin
          bad++;
          $display("FAIL mcast_dst j=%0d from=%h addr=%h word=%h want 04/1234/a5a5a5a5a5a5a5a5",
                   j, recv_from[j*N +: N], recv_addr[j*BADDR +: BADDR], recv_word[j*W +: W]);
        end
      end else begin
        total++;
        if (recv_from[j*N +: N] !== 8'h00 || recv_addr[j*BADDR +: BADDR] !== '0 || recv_word[j*W +: W] !== '0) begin
          bad++;
          $display("FAIL mcast_idle j=%0d from=%h addr=%h want zero", j, recv_from[j*N +: N], recv_addr[j*BADDR +: BADDR]);
        end
      end
    end
  endtask

  task automatic drive_contention();
    idle_inputs();
    send_en                     = 8'h48;
    send_to[3*N + 1]            = 1'b1;
    send_to[6*N + 1]            = 1'b1;
    send_addr[3*BADDR +: BADDR] = 15'h0333;
    send_addr[6*BADDR +: BADDR] = 15'h0666;
    send_word[3*W +: W]         = 64'h3333333333333333;
    send_word[6*W +: W]         = 64'h6666666666666666;
  endtask

  task automatic test_contention();
    pulse_reset();
    drive_contention();
    for (int c = 0; c < 4; c++) begin
      tick();
`ifdef INTERCONN_RR_ARB_EN
      exp_src  = (c % 2 == 0) ? 8'h08 : 8'h40;
      exp_word = (c % 2 == 0) ? 64'h3333333333333333 : 64'h6666666666666666;
`else
      exp_src  = 8'h08;
      exp_word = 64'h3333333333333333;
`endif
      total++;
      if (recv_en !== 8'h02 || recv_from[1*N +: N] !== exp_src) begin
        bad++;
        $display("FAIL contend_grant cyc=%0d en=%h from=%h want 02/%h", c, recv_en, recv_from[1*N +: N], exp_src);
      end
      total++;
      if (recv_word[1*W +: W] !== exp_word) begin
        bad++;
        $display("FAIL contend_word cyc=%0d got=%h want=%h", c, recv_word[1*W +: W], exp_word);
      end
    end
  endtask

  task automatic test_parallel();
    idle_inputs();
    send_en = 8'hff;
    for (int i = 0; i < N; i++) begin
      send_to[i*N + (i+1)%N]      = 1'b1;
      send_addr[i*BADDR +: BADDR] = 15'(16'h0100 + i);
      send_word[i*W +: W]         = {32'hc0de0000 + 32'(i), 32'h12345678};
    end
    tick();
    total++;
    if (recv_en !== 8'hff) begin
      bad++;
      $display("FAIL par_en got=%h want=ff", recv_en);
    end
    for (int j = 0; j < N; j++) begin
      exp_src  = N'(1) << ((j + N - 1) % N);
      exp_word = {32'hc0de0000 + 32'((j + N - 1) % N), 32'h12345678};
      total++;
      if (recv_from[j*N +: N] !== exp_src || recv_word[j*W +: W] !== exp_word ||
          recv_addr[j*BADDR +: BADDR] !== 15'(16'h0100 + (j + N - 1) % N)) begin
        bad++;
        $display("FAIL par_dst j=%0d from=%h word=%h want %h/%h", j, recv_from[j*N +: N], recv_word[j*W +: W], exp_src, exp_word);
      end
    end
  endtask

  task automatic test_mid_reset();
    pulse_reset();
    drive_contention();
    tick();
    tick();
    tick();
    clr = 1'b1;
    tick();
    total++;
    if (recv_en !== '0 || recv_from !== '0 || recv_addr !== '0 || recv_word !== '0) begin
      bad++;
      $display("FAIL midrst_clear en=%h from=%h want all zero", recv_en, recv_from);
    end
    clr = 1'b0;
    tick();
    total++;
    if (recv_en !== 8'h02 || recv_from[1*N +: N] !== 8'h08 || recv_word[1*W +: W] !== 64'h3333333333333333) begin
      bad++;
      $display("FAIL midrst_resume en=%h from=%h word=%h want 02/08/3333333333333333",
               recv_en, recv_from[1*N +: N], recv_word[1*W +: W]);
    end
    idle_inputs();
    tick();
    total++;
    if (recv_en !== '0 || recv_from !== '0) begin
      bad++;
      $display("FAIL midrst_idle en=%h from=%h want zero", recv_en, recv_from);
    end
  endtask

  initial begin
    clr = 1'b1;
    idle_inputs();
    test_reset();
    test_one_to_one();
    test_multicast();
    test_contention();
    test_parallel();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
